// File: rtl/unlock_pkg.sv
// Shared definitions for the unlock_seq code lock: state encoding, clear key
// and the sizing helper for the shared window/lockout timer.
package unlock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [7:0] CLEAR_CHAR = 8'h23;

  // The timer is loaded with (cycles - 1), so it must hold max(cycles) - 1.
  function automatic int timer_width(input int open_cycles, input int lockout_cycles);
    int longest;
    longest = (open_cycles > lockout_cycles) ? open_cycles : lockout_cycles;
    return (longest >= 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/unlock_timer.sv
// Loadable down-counter; expired pulses for one cycle once the loaded count has
// run down to zero, i.e. load_value + 1 cycles after the load edge.
module unlock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;
  logic         running;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_value;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - 1'b1;
    end
  end

  assign expired = running && (count == '0);

endmodule

// File: rtl/unlock_seq.sv
// Programmable code lock: fixed-length attempts against a runtime-reprogrammable
// code, with failed-attempt lockout and a timed unlock window.
module unlock_seq
  import unlock_pkg::*;
#(
  parameter int                         CHAR_W         = 8,
  parameter int                         CODE_LEN       = 4,
  parameter logic [CODE_LEN*CHAR_W-1:0] RESET_CODE     = "ABCD",
  parameter int                         MAX_TRIES      = 3,
  parameter int                         OPEN_CYCLES    = 8,
  parameter int                         LOCKOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHAR_W-1:0]                  char_in,
  input  logic                               char_valid,
  input  logic                               prog_en,
  output logic                               out,
  output logic                               locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
  output logic [1:0]                         state
);

  localparam int CODE_W = CODE_LEN * CHAR_W;
  localparam int POS_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FC_W   = $clog2(MAX_TRIES + 1);
  localparam int TW     = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);

  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  FAIL_MAX  = FC_W'(MAX_TRIES);
  localparam logic [TW-1:0]    OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]    LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  state_t             st;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  entry;
  logic [CODE_W-1:0]  stage;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   stage_pos;

  logic               is_clear;
  logic               entry_last;
  logic               stage_last;
  logic               match;
  logic [CODE_W-1:0]  entry_shift;
  logic [CODE_W-1:0]  stage_shift;
  logic [FC_W-1:0]    fail_next;
  logic               timer_load;
  logic [TW-1:0]      timer_value;
  logic               timer_expired;

  // Characters shift in at the LSB end, so the first one ends up in the MSBs.
  assign entry_shift = CODE_W'({entry, char_in});
  assign stage_shift = CODE_W'({stage, char_in});
  assign is_clear    = (char_in == CHAR_W'(CLEAR_CHAR));
  assign entry_last  = (pos == LAST_POS);
  assign stage_last  = (stage_pos == LAST_POS);
  assign match       = (entry_shift == code);
  assign fail_next   = fail_cnt + 1'b1;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = OPEN_LOAD;
    if (st == LOCKED && char_valid && !is_clear && entry_last) begin
      timer_load = 1'b1;
      if (!match) timer_value = LOCK_LOAD;
    end
  end

  unlock_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // NOTE: the code register and both buffers are a few flops, not a RAM, so
  // they take reset values; the code must come back as RESET_CODE anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= LOCKED;
      out        <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt   <= '0;
      code       <= RESET_CODE;
      entry      <= '0;
      pos        <= '0;
      stage      <= '0;
      stage_pos  <= '0;
    end else begin
      case (st)
        LOCKED: begin
          stage_pos <= '0;
          if (char_valid) begin
            if (is_clear) begin
              pos <= '0;
            end else if (entry_last) begin
              pos <= '0;
              if (match) begin
                st       <= OPEN;
                out      <= 1'b1;
                fail_cnt <= '0;
              end else if (fail_next == FAIL_MAX) begin
                st         <= LOCKOUT;
                locked_out <= 1'b1;
                fail_cnt   <= fail_next;
              end else begin
                fail_cnt <= fail_next;
              end
            end else begin
              entry <= entry_shift;
              pos   <= pos + 1'b1;
            end
          end
        end

        OPEN: begin
          // A completing character wins over expiry on the same edge: it was
          // presented while the window was still open.
          if (prog_en && char_valid && !is_clear && stage_last) begin
            code      <= stage_shift;
            st        <= LOCKED;
            out       <= 1'b0;
            stage_pos <= '0;
            pos       <= '0;
          end else if (timer_expired) begin
            st        <= LOCKED;
            out       <= 1'b0;
            stage_pos <= '0;
            pos       <= '0;
          end else if (!prog_en || (char_valid && is_clear)) begin
            stage_pos <= '0;
          end else if (char_valid) begin
            stage     <= stage_shift;
            stage_pos <= stage_pos + 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer_expired) begin
            st         <= LOCKED;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            pos        <= '0;
          end
        end

        default: begin
          st         <= LOCKED;
          out        <= 1'b0;
          locked_out <= 1'b0;
          pos        <= '0;
          stage_pos  <= '0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_unlock_seq.sv
// Scoreboard bench for unlock_seq: a queue-based reference model predicts every
// cycle's outputs; a separate monitor compares them on the falling edge.
module tb_unlock_seq;

  localparam int CHAR_W         = 8;
  localparam int CODE_LEN       = 4;
  localparam int MAX_TRIES      = 3;
  localparam int OPEN_CYCLES    = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int FC_W           = 2;
  localparam byte CLR           = 8'h23;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CHAR_W-1:0] char_in = '0;
  logic              char_valid = 1'b0;
  logic              prog_en = 1'b0;
  logic              out;
  logic              locked_out;
  logic [FC_W-1:0]   fail_cnt;
  logic [1:0]        state;

  unlock_seq #(
    .CHAR_W         (CHAR_W),
    .CODE_LEN       (CODE_LEN),
    .RESET_CODE     ("ABCD"),
    .MAX_TRIES      (MAX_TRIES),
    .OPEN_CYCLES    (OPEN_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .prog_en    (prog_en),
    .out        (out),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int o;
    int lo;
    int fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: 0 = locked, 1 = open, 2 = lockout; rem counts remaining cycles.
  int  m_mode;
  int  m_rem;
  int  m_fails;
  byte m_code[$];
  byte m_entry[$];
  byte m_stage[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode  = 0;
    m_rem   = 0;
    m_fails = 0;
    m_code  = '{8'h41, 8'h42, 8'h43, 8'h44};
    m_entry.delete();
    m_stage.delete();
  endfunction

  function automatic bit entry_matches();
    if (m_entry.size() != m_code.size()) return 1'b0;
    for (int i = 0; i < m_entry.size(); i++)
      if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input bit cv, input byte ch, input bit pe);
    bit done;
    done = 1'b0;
    case (m_mode)
      0: if (cv) begin
        if (ch == CLR) begin
          m_entry.delete();
        end else begin
          m_entry.push_back(ch);
          if (m_entry.size() == CODE_LEN) begin
            if (entry_matches()) begin
              m_mode  = 1;
              m_rem   = OPEN_CYCLES;
              m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails == MAX_TRIES) begin
                m_mode = 2;
                m_rem  = LOCKOUT_CYCLES;
              end
            end
            m_entry.delete();
          end
        end
      end
      1: begin
        if (pe && cv && ch != CLR) begin
          m_stage.push_back(ch);
          if (m_stage.size() == CODE_LEN) begin
            m_code = m_stage;
            done   = 1'b1;
          end
        end else if (!pe || (cv && ch == CLR)) begin
          m_stage.delete();
        end
        m_rem--;
        if (done || m_rem == 0) begin
          m_mode = 0;
          m_stage.delete();
          m_entry.delete();
        end
      end
      default: begin
        m_rem--;
        if (m_rem == 0) begin
          m_mode  = 0;
          m_fails = 0;
          m_entry.delete();
        end
      end
    endcase
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.st = m_mode;
    e.o  = (m_mode == 1) ? 1 : 0;
    e.lo = (m_mode == 2) ? 1 : 0;
    e.fc = m_fails;
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input bit cv, input byte ch, input bit pe);
    char_valid = cv;
    char_in    = ch;
    prog_en    = pe;
    @(posedge clk);
    model_step(cv, ch, pe);
    push_expected();
    #1;
  endtask

  // Reset is asserted between edges so the falling-edge check sees it take
  // effect before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset      = 1'b0;
    char_valid = 1'b0;
    prog_en    = 1'b0;
    model_reset();
    push_expected();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send(input string s, input bit pe);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], pe);
  endtask

  task automatic idle(input int n, input bit pe);
    for (int i = 0; i < n; i++) cycle(1'b0, byte'($urandom_range(65, 90)), pe);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", 32'(state), e.st);
        check("out", 32'(out), e.o);
        check("locked_out", 32'(locked_out), e.lo);
        check("fail_cnt", 32'(fail_cnt), e.fc);
      end
    end
  end

  initial begin : driver
    byte alpha[8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h57, 8'h58, 8'h23, 8'h54};
    byte code_copy[$];
    model_reset();

    // 1: basic unlock and window length
    do_reset();
    idle(2, 1'b0);
    send("ABCD", 1'b0);
    idle(10, 1'b0);

    // 2: one failure, then clear-discarded partial entry and success
    send("ABCA", 1'b0);
    send("AB#ABCD", 1'b0);
    idle(10, 1'b0);

    // 3: lockout after three failures; correct code ignored during lockout
    for (int i = 0; i < 3; i++) send("DCBT", 1'b0);
    send("ABCD", 1'b0);
    idle(16, 1'b0);
    send("ABCD", 1'b0);
    idle(10, 1'b0);

    // 4: reprogram to WXYZ
    send("ABCD", 1'b0);
    send("WXYZ", 1'b1);
    idle(2, 1'b0);
    send("ABCD", 1'b0);
    idle(2, 1'b0);
    send("WXYZ", 1'b0);
    idle(10, 1'b0);

    // 5: aborted programming by prog_en drop, clear char and window expiry
    do_reset();
    send("ABCD", 1'b0);
    send("WX", 1'b1);
    cycle(1'b0, 8'h41, 1'b0);
    send("YZ", 1'b1);
    idle(8, 1'b0);
    send("WXYZ", 1'b0);
    send("ABCD", 1'b0);
    send("WX#YZ", 1'b1);
    idle(8, 1'b0);
    send("WXYZ", 1'b0);
    send("ABCD", 1'b0);
    send("WX", 1'b1);
    idle(10, 1'b1);
    send("WXYZ", 1'b0);
    send("ABCD", 1'b0);
    idle(10, 1'b0);

    // 6: reset mid-entry, during lockout, and after reprogramming
    send("AB", 1'b0);
    do_reset();
    send("ABCD", 1'b0);
    idle(10, 1'b0);
    for (int i = 0; i < 3; i++) send("DCBT", 1'b0);
    idle(5, 1'b0);
    do_reset();
    send("ABCD", 1'b0);
    idle(10, 1'b0);
    send("ABCD", 1'b0);
    send("WXYZ", 1'b1);
    idle(2, 1'b0);
    do_reset();
    send("ABCD", 1'b0);
    idle(10, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit cv;
      bit pe;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else if (r < 8 && m_mode == 0 && m_entry.size() == 0) begin
        code_copy = m_code;
        for (int k = 0; k < CODE_LEN; k++) cycle(1'b1, code_copy[k], 1'b0);
      end else if (r < 25 && m_mode == 1) begin
        for (int k = 0; k < CODE_LEN; k++) cycle(1'b1, alpha[$urandom_range(0, 5)], 1'b1);
      end else begin
        cv = ($urandom_range(0, 9) < 7);
        pe = (m_mode == 1) ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
        cycle(cv, alpha[$urandom_range(0, 7)], pe);
      end
    end

    @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unlock_seq.md
Name: unlock_seq

Overview:
Parametrised successor to the single-code ASCII lock. It accepts a strobed character stream and compares fixed-length attempts against a stored code, which can be reprogrammed at runtime. It counts failed attempts and enforces a timed lockout, and it holds an unlock window for a fixed number of cycles. It sits between the keypad/UART character front end and the door/actuator control logic.

Parameters:
CHAR_W, 8, character width in bits.
CODE_LEN, 4, characters per attempt; minimum 1.
RESET_CODE, "ABCD", code loaded at reset, packed CODE_LEN*CHAR_W bits; the first character is in the MSBs.
MAX_TRIES, 3, consecutive failed attempts that trigger lockout; minimum 1.
OPEN_CYCLES, 8, clock cycles `out` stays high after a correct attempt; minimum 1.
LOCKOUT_CYCLES, 16, clock cycles spent in lockout; minimum 1.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
char_in  input  CHAR_W  character code (ASCII).
char_valid  input  1  char_in is sampled on the rising clk edge where this is 1.
prog_en  input  1  while in OPEN, valid characters are treated as a new code.
out  output  1  unlocked indication; high while in OPEN.
locked_out  output  1  high while in LOCKOUT.
fail_cnt  output  $clog2(MAX_TRIES+1)  consecutive failed attempts.
state  output  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOCKED, out=0, locked_out=0, fail_cnt=0.
  - code register=RESET_CODE; entry position=0; timer=0.
- All outputs are registered. Every transition below takes effect on the sampling edge and is visible the cycle after it.
- LOCKED (state 0):
  - A valid character other than CLEAR_CHAR is stored at the entry position and the position increments.
  - CLEAR_CHAR sets the position to 0 and does not change fail_cnt.
  - On the CODE_LEN-th character, the entry including that character is compared with the code register, and the position returns to 0.
  - On a match: go to OPEN, set fail_cnt=0, load timer=OPEN_CYCLES-1.
  - On a mismatch: fail_cnt+1. If the new count equals MAX_TRIES, go to LOCKOUT and load timer=LOCKOUT_CYCLES-1.
- OPEN (state 1):
  - out=1 for exactly OPEN_CYCLES cycles, then return to LOCKED with the position at 0.
  - Valid characters with prog_en=0 are ignored.
  - Valid characters with prog_en=1 fill a staging buffer.
  - On the CODE_LEN-th staged character, the code register takes the staged value and the state goes to LOCKED on that same edge. This ends the window early.
- Programming aborts: the staged buffer is discarded and the code is unchanged if any of these occur before completion:
  - prog_en drops;
  - CLEAR_CHAR is staged;
  - the timer expires.
  CLEAR_CHAR can therefore never be part of a code.
- LOCKOUT (state 2):
  - locked_out=1 and all characters are ignored.
  - fail_cnt holds at MAX_TRIES.
  - After LOCKOUT_CYCLES cycles: go to LOCKED, set fail_cnt=0, position=0.
- State 3 is unreachable. If it is entered, the FSM goes to LOCKED on the next edge.
- char_valid=0 means no action; idle cycles do not time out a partial entry.
- MAX_TRIES=1: a single wrong attempt triggers lockout.
- A timer value of 0 loaded at entry means the state lasts one cycle.
- Reset asserted mid-entry, mid-programming, or in LOCKOUT: immediate return to reset values. A previously programmed code is lost, and RESET_CODE is restored.

Decomposition:
- Package unlock_pkg holds:
  - the state encoding: LOCKED=2'd0, OPEN=2'd1, LOCKOUT=2'd2;
  - CLEAR_CHAR=8'h23 ("#");
  - a function that returns the timer width from OPEN_CYCLES and LOCKOUT_CYCLES.
- One sub-module, unlock_timer:
  - loadable down-counter: load, load_value, expired pulse, async active-low reset;
  - shared between OPEN and LOCKOUT.
- The entry buffer, staging buffer and comparator stay in unlock_seq.

Test Plan:
1. Release reset, then send A,B,C,D, one per cycle. Required: out=1 starting the cycle after D, for exactly 8 cycles, then 0; fail_cnt=0.
2. Send A,B,C,A, then A,B,#,A,B,C,D. Required: fail_cnt=1 after the first attempt; # discards the partial entry without adding a failure; out rises after D; fail_cnt clears to 0.
3. Send three wrong attempts (D,C,B,T x3). Required: fail_cnt steps 1,2,3; locked_out=1 for 16 cycles; A,B,C,D sent during lockout gives no out. After lockout ends, A,B,C,D opens.
4. Unlock, then with prog_en=1 send W,X,Y,Z. Required: state=LOCKED the cycle after Z. A,B,C,D now counts as a failure; W,X,Y,Z opens.
5. Unlock, then with prog_en=1 send W,X, then drop prog_en (or send #, or let the 8-cycle window expire). Required: code stays ABCD; W,X,Y,Z counts as a failure.
6. Assert reset mid-attempt after A,B and during LOCKOUT. Required: out=0, locked_out=0, fail_cnt=0 immediately. Then A,B,C,D opens, including after a code was reprogrammed before the reset.
